// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg: shared state encoding, requester ids, defaults and helpers for the LCD update arbiter
package lcd_arb_pkg;
  typedef enum logic [1:0] {IDLE, LCD_REQ, LCD_REL, REQ_ACK} state_e;
  localparam logic REQ_RT = 1'b0;
  localparam logic REQ_STATS = 1'b1;
  localparam int DATA_W_DEF = 16;
  localparam int TIMEOUT_CYC_DEF = 50;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/lcd_update_arbiter_if.sv
// lcd_update_arbiter_if: requester, LCD-driver and status signals around the LCD update arbiter
interface lcd_update_arbiter_if import lcd_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              Req0Update, Req0Ack, Req1Update, Req1Ack;
  logic              LCDUpdate, LCDAck, Owner, Busy, TimeoutErr;
  logic [DATA_W-1:0] Req0Data, Req1Data, LCDData;
  modport slave (
    input  Req0Update, Req0Data, Req1Update, Req1Data, LCDAck,
    output Req0Ack, Req1Ack, LCDUpdate, LCDData, Owner, Busy, TimeoutErr
  );
  modport master (
    output Req0Update, Req0Data, Req1Update, Req1Data, LCDAck,
    input  Req0Ack, Req1Ack, LCDUpdate, LCDData, Owner, Busy, TimeoutErr
  );
endinterface

// File: rtl/lcd_arb_wdog.sv
// lcd_arb_wdog: cycle counter that flags when TIMEOUT_CYC enabled cycles pass without a clear
module lcd_arb_wdog import lcd_arb_pkg::*; #(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (clr_i | ~en_i) ? '0 : cnt_q + 1'b1;
  assign expired_o = en_i && cnt_q == W'(TIMEOUT_CYC - 1);
  // count enabled cycles, restart on clear or when disabled
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lcd_update_arbiter.sv
// lcd_update_arbiter: round-robin share of one LCD driver port between two four-phase requesters (watchdog under LCD_ARB_TIMEOUT_EN)
module lcd_update_arbiter import lcd_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
`ifdef LCD_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input logic Clk,
  input logic Rst,
  lcd_update_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  logic              owner_q, last_q, lu_q, a0_q, a1_q, busy_q;
  logic              expired, pick, own_upd, grant;
  logic [DATA_W-1:0] data_q;
  assign own_upd = owner_q ? bus.Req1Update : bus.Req0Update;
  assign pick = (bus.Req0Update & bus.Req1Update) ? ~last_q : (bus.Req1Update ? REQ_STATS : REQ_RT);
  assign grant = state_q == IDLE && state_d == LCD_REQ;
  // next state: grant, LCD-side four-phase handshake, then requester-side release
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (bus.Req0Update | bus.Req1Update) ? LCD_REQ : IDLE;
      LCD_REQ: state_d = expired ? REQ_ACK : (bus.LCDAck ? LCD_REL : LCD_REQ);
      LCD_REL: state_d = (expired | ~bus.LCDAck) ? REQ_ACK : LCD_REL;
      REQ_ACK: state_d = own_upd ? REQ_ACK : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // registered outputs decoded from the next state; message and owner held from grant to grant
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      owner_q <= REQ_RT;
      last_q  <= REQ_STATS;
      data_q  <= '0;
      lu_q    <= 1'b0;
      a0_q    <= 1'b0;
      a1_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= grant ? pick : owner_q;
      data_q  <= grant ? (pick ? bus.Req1Data : bus.Req0Data) : data_q;
      last_q  <= (state_q == REQ_ACK && state_d == IDLE) ? owner_q : last_q;
      lu_q    <= state_d == LCD_REQ;
      a0_q    <= state_d == REQ_ACK && owner_q == REQ_RT;
      a1_q    <= state_d == REQ_ACK && owner_q == REQ_STATS;
      busy_q  <= state_d != IDLE;
    end
  end
`ifdef LCD_ARB_TIMEOUT_EN
  logic terr_q;
  lcd_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk      (Clk),
    .rst      (Rst),
    .clr_i    (state_d != state_q),
    .en_i     (state_q == LCD_REQ || state_q == LCD_REL),
    .expired_o(expired)
  );
  // sticky watchdog error, cleared only by reset
  always_ff @(posedge Clk) begin
    if (Rst) terr_q <= 1'b0;
    else terr_q <= terr_q | expired;
  end
  assign bus.TimeoutErr = terr_q;
`else
  assign expired = 1'b0;
  assign bus.TimeoutErr = 1'b0;
`endif
  assign bus.LCDUpdate = lu_q;
  assign bus.LCDData   = data_q;
  assign bus.Req0Ack   = a0_q;
  assign bus.Req1Ack   = a1_q;
  assign bus.Owner     = owner_q;
  assign bus.Busy      = busy_q;
endmodule
